// File: rtl/axis_arb_pkg.sv
// Shared definitions for the packet-granular AXI-Stream round-robin arbiter.
// Holds the FSM state encoding, the default beat width and an index-width helper.
package axis_arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_LOCK = 1'b1;

  localparam int DEF_DATA_W = 8;

  // Bits needed to index n items, never less than one so 1-entry ranges stay legal.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping at N.
// Purely combinational; found=0 leaves idx at 0.
module rr_priority_pick
  import axis_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Walk from the farthest offset down so the nearest requester to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Merges NUM_SRC AXI-Stream sources onto one registered output, round-robin per packet.
// A grant is held until the (possibly length-forced) last beat is accepted.
module axis_rr_packet_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC*DATA_W-1:0]   s_data,
  input  logic [NUM_SRC-1:0]          s_valid,
  input  logic [NUM_SRC-1:0]          s_last,
  output logic [NUM_SRC-1:0]          s_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic [idx_w(NUM_SRC)-1:0]   grant_id,
  output logic                        busy
);

  localparam int   IW     = idx_w(NUM_SRC);
  localparam int   CW     = idx_w(MAX_BEATS + 1);
  localparam int   LIM    = (MAX_BEATS == 0) ? 0 : MAX_BEATS - 1;
  localparam logic LIM_EN = (MAX_BEATS != 0);

  logic              state_q, state_d;
  logic [IW-1:0]     rr_ptr;
  logic [CW-1:0]     beat_cnt;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;
  logic              out_free;
  logic              sel_valid, sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              accept, eff_last;
  logic [IW-1:0]     next_ptr;

  rr_priority_pick #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_pick (
    .req   (s_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_free  = !m_valid || m_ready;
  assign sel_valid = s_valid[grant_id];
  assign sel_last  = s_last[grant_id];
  assign sel_data  = s_data[int'(grant_id)*DATA_W +: DATA_W];
  // The length limit closes the packet on its own; leftover beats re-arbitrate later.
  assign eff_last  = sel_last || (LIM_EN && (beat_cnt == CW'(LIM)));
  assign next_ptr  = (grant_id == IW'(NUM_SRC - 1)) ? '0 : grant_id + IW'(1);
  assign busy      = (state_q == ST_LOCK);

  always_comb begin
    state_d = state_q;
    s_ready = '0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) state_d = ST_LOCK;
      end
      default: begin
        s_ready[grant_id] = out_free;
        accept            = sel_valid && out_free;
        if (accept && eff_last) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && pick_found) grant_id <= pick_idx;
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= sel_data;
        m_last  <= eff_last;
        if (eff_last) begin
          beat_cnt <= '0;
          rr_ptr   <= next_ptr;
        end else if (beat_cnt != '1) begin
          beat_cnt <= beat_cnt + CW'(1);
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: per-source beat queues drive the inputs,
// a monitor logs accepted output beats with their cycle number for ordering/timing checks.
module tb_axis_rr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = '0;
  logic [3:0]  s_valid = '0;
  logic [3:0]  s_last = '0;
  logic [3:0]  s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [1:0]  grant_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] srcq [4][$];
  logic [3:0] hold = '0;
  logic [3:0] hs = '0;
  logic [8:0] outq [$];
  int         outc [$];

  axis_rr_packet_arbiter #(.NUM_SRC(4), .DATA_W(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Handshakes are sampled at negedge; inputs only move at posedge+1, so this equals the edge value.
  always @(negedge clk) begin
    hs = s_valid & s_ready;
    if (m_valid && m_ready) begin
      outq.push_back({m_last, m_data});
      outc.push_back(cyc);
    end
  end

  always @(posedge clk) begin
    logic [8:0] tmp;
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (hs[i] && srcq[i].size() > 0) tmp = srcq[i].pop_front();
      if (srcq[i].size() > 0 && !hold[i]) begin
        s_valid[i]         = 1'b1;
        s_data[i*8 +: 8]   = srcq[i][0][7:0];
        s_last[i]          = srcq[i][0][8];
      end else begin
        s_valid[i] = 1'b0;
        s_last[i]  = 1'b0;
      end
    end
  end

  function automatic bit any_pending();
    bit p = 1'b0;
    for (int i = 0; i < 4; i++) if (srcq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  task automatic wait_drain(input string nm);
    int n = 0;
    while (n < 300 && (any_pending() || m_valid || busy)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s drain: still pending after %0d cycles, required empty", nm, n);
    end
  endtask

  task automatic check_out(input string nm, input logic [8:0] exp [], input int count);
    checks++;
    if (outq.size() != count) begin
      errors++;
      $display("FAIL %s beat count: got %0d required %0d", nm, outq.size(), count);
    end
    for (int k = 0; k < count && k < outq.size(); k++) begin
      checks++;
      if (outq[k] !== exp[k]) begin
        errors++;
        $display("FAIL %s beat %0d: got last=%b data=%h required last=%b data=%h",
                 nm, k, outq[k][8], outq[k][7:0], exp[k][8], exp[k][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bit got;
    for (int i = 0; i < 4; i++) srcq[i].push_back({1'b1, 8'(8'h0F + i*16)});
    repeat (2) @(negedge clk);
    checks++; if (s_ready !== 4'b0) begin errors++; $display("FAIL reset s_ready: got %b required 0000", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset m_valid: got %b required 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset m_last: got %b required 0", m_last); end
    checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset m_data: got %h required 00", m_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset grant_id: got %0d required 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b required 0", busy); end
    rst = 1'b0;
    got = 1'b0;
    n = 0;
    while (!got && n < 2) begin
      @(negedge clk);
      n++;
      if (busy) got = 1'b1;
    end
    checks++;
    if (!got || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset first grant: got busy=%b grant=%0d required busy=1 grant=0", got, grant_id);
    end
    wait_drain("reset");
    outq.delete(); outc.delete();
  endtask

  task automatic test_round_robin();
    logic [8:0] exp [];
    exp = new[10];
    exp = '{9'h001, 9'h102, 9'h011, 9'h112, 9'h021, 9'h122, 9'h031, 9'h132, 9'h003, 9'h104};
    m_ready = 1'b1;
    srcq[0].push_back(9'h001); srcq[0].push_back(9'h102);
    srcq[0].push_back(9'h003); srcq[0].push_back(9'h104);
    for (int i = 1; i < 4; i++) begin
      srcq[i].push_back({1'b0, 8'(i*16 + 1)});
      srcq[i].push_back({1'b1, 8'(i*16 + 2)});
    end
    wait_drain("round_robin");
    check_out("round_robin", exp, 10);
    for (int k = 1; k < 10 && k < outc.size(); k++) begin
      int want;
      want = (k % 2 == 0) ? 2 : 1;
      checks++;
      if (outc[k] - outc[k-1] !== want) begin
        errors++;
        $display("FAIL round_robin spacing %0d: got %0d cycles required %0d", k, outc[k] - outc[k-1], want);
      end
    end
    outq.delete(); outc.delete();
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [8:0] exp [];
    exp = new[3];
    exp = '{9'h0A1, 9'h0A2, 9'h1A3};
    m_ready = 1'b0;
    srcq[1].push_back(9'h0A1); srcq[1].push_back(9'h0A2); srcq[1].push_back(9'h1A3);
    while (!m_valid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hA1) begin
      errors++;
      $display("FAIL backpressure first beat: got v=%b data=%h required v=1 data=a1", m_valid, m_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'hA1) begin
        errors++;
        $display("FAIL backpressure hold c%0d: got v=%b data=%h required v=1 data=a1", c, m_valid, m_data);
      end
      checks++;
      if (s_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL backpressure s_ready c%0d: got %b required 0", c, s_ready[1]);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_drain("backpressure");
    check_out("backpressure", exp, 3);
    outq.delete(); outc.delete();
  endtask

  task automatic test_no_interleave();
    int n = 0;
    logic [8:0] exp [];
    exp = new[5];
    exp = '{9'h0B0, 9'h0B1, 9'h0B2, 9'h1B3, 9'h1C0};
    for (int k = 0; k < 4; k++) srcq[0].push_back({(k == 3), 8'(8'hB0 + k)});
    while (!(busy && grant_id == 2'd0) && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (!(busy && grant_id == 2'd0)) begin
      errors++;
      $display("FAIL no_interleave src0 grant: got busy=%b grant=%0d required busy=1 grant=0", busy, grant_id);
    end
    srcq[2].push_back(9'h1C0);
    n = 0;
    while (srcq[0].size() > 2 && n < 20) begin @(negedge clk); n++; end
    hold[0] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (s_ready[2] !== 1'b0 || grant_id !== 2'd0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL no_interleave gap c%0d: got rdy2=%b grant=%0d busy=%b required 0/0/1",
                 c, s_ready[2], grant_id, busy);
      end
    end
    hold[0] = 1'b0;
    wait_drain("no_interleave");
    check_out("no_interleave", exp, 5);
    outq.delete(); outc.delete();
  endtask

  task automatic test_truncation();
    logic [8:0] exp [];
    exp = new[20];
    for (int k = 0; k < 20; k++) begin
      srcq[3].push_back({(k == 19), 8'(8'h40 + k)});
      exp[k] = {(k == 15 || k == 19), 8'(8'h40 + k)};
    end
    wait_drain("truncation");
    check_out("truncation", exp, 20);
    if (outc.size() == 20) begin
      checks++;
      if (outc[16] - outc[15] !== 2) begin
        errors++;
        $display("FAIL truncation re-arbitration gap: got %0d required 2", outc[16] - outc[15]);
      end
      checks++;
      if (outc[19] - outc[16] !== 3) begin
        errors++;
        $display("FAIL truncation tail span: got %0d required 3", outc[19] - outc[16]);
      end
    end
    outq.delete(); outc.delete();
  endtask

  task automatic test_mid_reset();
    int n = 0;
    logic [8:0] exp [];
    exp = new[4];
    exp = '{9'h1E1, 9'h0D0, 9'h0D1, 9'h1D2};
    srcq[2].push_back(9'h1E2);
    wait_drain("mid_reset pre");
    srcq[3].push_back(9'h0D0); srcq[3].push_back(9'h0D1); srcq[3].push_back(9'h1D2);
    while (srcq[3].size() > 1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hD1) begin
      errors++;
      $display("FAIL mid_reset beat2: got v=%b data=%h required v=1 data=d1", m_valid, m_data);
    end
    rst = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_reset m_valid: got %b required 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %b required 0", busy); end
    checks++; if (s_ready !== 4'b0) begin errors++; $display("FAIL mid_reset s_ready: got %b required 0000", s_ready); end
    @(posedge clk); #2;
    srcq[3].delete();
    srcq[1].push_back(9'h1E1);
    srcq[3].push_back(9'h0D0); srcq[3].push_back(9'h0D1); srcq[3].push_back(9'h1D2);
    repeat (2) @(negedge clk);
    outq.delete(); outc.delete();
    rst = 1'b0;
    n = 0;
    while (!busy && n < 5) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL mid_reset regrant: got busy=%b grant=%0d required busy=1 grant=1", busy, grant_id);
    end
    wait_drain("mid_reset");
    check_out("mid_reset", exp, 4);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_no_interleave();
    test_truncation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

endmodule
